// File: rtl/bp_me_xui_cmd_sequencer_if.sv
// Upstream command / read-return port and MIG UI port of the XUI command
// sequencer, bundled so both sides share one declaration.
interface bp_me_xui_cmd_sequencer_if #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 512
);
  logic                      cmd_v_i;
  logic                      cmd_ready_o;
  logic                      cmd_we_i;
  logic [addr_width_p-1:0]   cmd_addr_i;
  logic [data_width_p-1:0]   cmd_data_i;
  logic [data_width_p/8-1:0] cmd_mask_i;
  logic [data_width_p-1:0]   rdata_o;
  logic                      rdata_v_o;
  logic                      rdata_yumi_i;
  logic [addr_width_p-1:0]   app_addr_o;
  logic [2:0]                app_cmd_o;
  logic                      app_en_o;
  logic                      app_rdy_i;
  logic                      app_wdf_wren_o;
  logic [data_width_p-1:0]   app_wdf_data_o;
  logic [data_width_p/8-1:0] app_wdf_mask_o;
  logic                      app_wdf_end_o;
  logic                      app_wdf_rdy_i;
  logic                      app_rd_data_valid_i;
  logic [data_width_p-1:0]   app_rd_data_i;
  logic                      app_rd_data_end_i;

  modport slave (
    input  cmd_v_i, cmd_we_i, cmd_addr_i,
    input  cmd_data_i, cmd_mask_i,
    input  rdata_yumi_i, app_rdy_i,
    input  app_wdf_rdy_i, app_rd_data_valid_i,
    input  app_rd_data_i, app_rd_data_end_i,
    output cmd_ready_o, rdata_o, rdata_v_o,
    output app_addr_o, app_cmd_o, app_en_o,
    output app_wdf_wren_o, app_wdf_data_o,
    output app_wdf_mask_o, app_wdf_end_o
  );

  modport master (
    output cmd_v_i, cmd_we_i, cmd_addr_i,
    output cmd_data_i, cmd_mask_i,
    output rdata_yumi_i, app_rdy_i,
    output app_wdf_rdy_i, app_rd_data_valid_i,
    output app_rd_data_i, app_rd_data_end_i,
    input  cmd_ready_o, rdata_o, rdata_v_o,
    input  app_addr_o, app_cmd_o, app_en_o,
    input  app_wdf_wren_o, app_wdf_data_o,
    input  app_wdf_mask_o, app_wdf_end_o
  );
endinterface

// File: rtl/bp_me_xui_cmd_sequencer.sv
// One-block-at-a-time command sequencer between the CCE-to-XUI adapter and
// the MIG UI, with a credit-protected read-return FIFO.
module bp_me_xui_cmd_sequencer #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 512,
  parameter int max_reads_p  = 8
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic calib_done_i,
  bp_me_xui_cmd_sequencer_if.slave bus,
  output logic overflow_o
);
  localparam int mask_w_lp = data_width_p/8;
  localparam int ptr_w_lp  = $clog2(max_reads_p);
  localparam int cred_w_lp = $clog2(max_reads_p+1);
  localparam logic [cred_w_lp-1:0] cred_max_lp =
    cred_w_lp'(max_reads_p);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic                    r_cmd_pend;
  logic                    r_wdf_pend;
  logic                    r_we;
  logic [addr_width_p-1:0] r_addr;
  logic [data_width_p-1:0] r_data;
  logic [mask_w_lp-1:0]    r_mask;
  logic [cred_w_lp-1:0]    r_cred;
  logic [ptr_w_lp:0]       r_wptr;
  logic [ptr_w_lp:0]       r_rptr;
  logic [data_width_p-1:0] r_mem [max_reads_p];
  logic                    r_ovf;

  logic w_accept;
  logic w_cmd_done;
  logic w_wdf_done;
  logic w_cmd_pend_nxt;
  logic w_wdf_pend_nxt;
  logic w_rd_take;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_unused_rd_end;

  assign w_unused_rd_end = bus.app_rd_data_end_i;

  assign w_accept   = bus.cmd_v_i & bus.cmd_ready_o;
  assign w_cmd_done = r_cmd_pend & bus.app_rdy_i;
  assign w_wdf_done = r_wdf_pend & bus.app_wdf_rdy_i;
  assign w_rd_take  = w_accept & ~bus.cmd_we_i;

  assign w_cmd_pend_nxt = w_accept | (r_cmd_pend & ~w_cmd_done);
  assign w_wdf_pend_nxt = w_accept ? bus.cmd_we_i
                                   : (r_wdf_pend & ~w_wdf_done);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_accept) w_state_nxt = ISSUE;
      ISSUE: if (!w_cmd_pend_nxt && !w_wdf_pend_nxt)
               w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ready is gated by reset so every output reads 0 while held in reset.
  always_comb begin
    bus.cmd_ready_o    = reset_n_i & calib_done_i &
                         (r_state == IDLE) & (r_cred != '0);
    bus.app_en_o       = r_cmd_pend;
    bus.app_addr_o     = r_cmd_pend ? r_addr : '0;
    bus.app_cmd_o      = r_cmd_pend ? {2'b00, ~r_we} : 3'b000;
    bus.app_wdf_wren_o = r_wdf_pend;
    bus.app_wdf_end_o  = r_wdf_pend;
    bus.app_wdf_data_o = r_wdf_pend ? r_data : '0;
    bus.app_wdf_mask_o = r_wdf_pend ? ~r_mask : '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cmd_pend <= 1'b0;
      r_wdf_pend <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
    end else begin
      r_cmd_pend <= w_cmd_pend_nxt;
      r_wdf_pend <= w_wdf_pend_nxt;
      if (w_accept) begin
        r_we   <= bus.cmd_we_i;
        r_addr <= bus.cmd_addr_i;
        r_data <= bus.cmd_data_i;
        r_mask <= bus.cmd_mask_i;
      end
    end
  end

  // Extra pointer bit distinguishes full from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ptr_w_lp] != r_rptr[ptr_w_lp]) &&
                   (r_wptr[ptr_w_lp-1:0] == r_rptr[ptr_w_lp-1:0]);
  assign w_pop   = bus.rdata_yumi_i & ~w_empty;
  assign w_push  = bus.app_rd_data_valid_i & (~w_full | w_pop);

  assign bus.rdata_v_o = ~w_empty;
  assign bus.rdata_o   = w_empty ? '0
                                 : r_mem[r_rptr[ptr_w_lp-1:0]];
  assign overflow_o    = r_ovf;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr[ptr_w_lp-1:0]] <= bus.app_rd_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_cred <= cred_max_lp;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (bus.app_rd_data_valid_i && w_full && !w_pop)
        r_ovf <= 1'b1;
      if (w_rd_take && !w_pop)      r_cred <= r_cred - 1'b1;
      else if (w_pop && !w_rd_take) r_cred <= r_cred + 1'b1;
    end
  end

  a_cred_hi: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(r_cred == cred_max_lp && w_pop && !w_rd_take));
  a_cred_lo: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(r_cred == '0 && w_rd_take && !w_pop));

endmodule

// File: tb/tb_bp_me_xui_cmd_sequencer.sv
// Bench for bp_me_xui_cmd_sequencer: per-cycle vector table for the command
// channels, queue scoreboard for read return, FIFO-full and async reset cases.
module tb_bp_me_xui_cmd_sequencer;
  localparam int AW = 28;
  localparam int DW = 512;
  localparam int MW = DW/8;

  typedef struct {
    logic [4:0]    in;
    logic [AW-1:0] addr;
    logic [7:0]    db;
    logic [MW-1:0] mask;
    logic [2:0]    ex;
    logic [2:0]    ecmd;
    logic [AW-1:0] eaddr;
    logic [7:0]    edb;
    logic [MW-1:0] emask;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic calib = 1'b0;
  logic ovf;
  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] sb[$];
  vec_t vt[13];

  bp_me_xui_cmd_sequencer_if #(.addr_width_p(AW), .data_width_p(DW)) bus();

  bp_me_xui_cmd_sequencer #(
    .addr_width_p(AW), .data_width_p(DW), .max_reads_p(8)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .calib_done_i(calib),
    .bus(bus.slave), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dpat(input int k);
    return {16{32'hD000_0000 + 32'(k)}};
  endfunction

  task automatic issue(input logic we, input logic [AW-1:0] a);
    bus.cmd_v_i    = 1'b1;
    bus.cmd_we_i   = we;
    bus.cmd_addr_i = a;
    bus.cmd_data_i = {MW{8'h5A}};
    bus.cmd_mask_i = '1;
    #1;
    for (int k = 0; k < 20 && !bus.cmd_ready_o; k++) begin
      @(posedge clk);
      #2;
    end
    chk("issue_ready", 512'(bus.cmd_ready_o), 512'(1'b1));
    @(posedge clk);
    #1;
    bus.cmd_v_i = 1'b0;
  endtask

  task automatic mig_return(input int k);
    bus.app_rd_data_valid_i = 1'b1;
    bus.app_rd_data_i = dpat(k);
    sb.push_back(dpat(k));
    tick();
    bus.app_rd_data_valid_i = 1'b0;
  endtask

  task automatic pop_n(input int n);
    logic [DW-1:0] e;
    for (int j = 0; j < n; j++) begin
      #1;
      chk("pop_valid", 512'(bus.rdata_v_o), 512'(1'b1));
      e = (sb.size() != 0) ? sb.pop_front() : 'x;
      chk("pop_data", bus.rdata_o, e);
      bus.rdata_yumi_i = 1'b1;
      tick();
      bus.rdata_yumi_i = 1'b0;
    end
  endtask

  initial begin
    vt[0]  = '{5'b01000, 28'h0, 8'h00, '0, 3'b000,
               3'd0, 28'h0, 8'h00, '0};
    vt[1]  = '{5'b10000, 28'h0, 8'h00, '0, 3'b100,
               3'd0, 28'h0, 8'h00, '0};
    vt[2]  = '{5'b11111, 28'h100, 8'hA5, '1, 3'b100,
               3'd0, 28'h0, 8'h00, '0};
    vt[3]  = '{5'b10011, 28'h0, 8'h00, '0, 3'b011,
               3'd0, 28'h100, 8'hA5, '0};
    vt[4]  = '{5'b10011, 28'h0, 8'h00, '0, 3'b100,
               3'd0, 28'h0, 8'h00, '0};
    vt[5]  = '{5'b11100, 28'h2C0, 8'h3C, 64'h0000_0000_FFFF_FFFF,
               3'b100, 3'd0, 28'h0, 8'h00, '0};
    vt[6]  = '{5'b10000, 28'h0, 8'h00, '0, 3'b011,
               3'd0, 28'h2C0, 8'h3C, 64'hFFFF_FFFF_0000_0000};
    vt[7]  = '{5'b10000, 28'h0, 8'h00, '0, 3'b011,
               3'd0, 28'h2C0, 8'h3C, 64'hFFFF_FFFF_0000_0000};
    vt[8]  = '{5'b10001, 28'h0, 8'h00, '0, 3'b011,
               3'd0, 28'h2C0, 8'h3C, 64'hFFFF_FFFF_0000_0000};
    vt[9]  = '{5'b10000, 28'h0, 8'h00, '0, 3'b010,
               3'd0, 28'h2C0, 8'h00, '0};
    vt[10] = '{5'b10000, 28'h0, 8'h00, '0, 3'b010,
               3'd0, 28'h2C0, 8'h00, '0};
    vt[11] = '{5'b10010, 28'h0, 8'h00, '0, 3'b010,
               3'd0, 28'h2C0, 8'h00, '0};
    vt[12] = '{5'b10000, 28'h0, 8'h00, '0, 3'b100,
               3'd0, 28'h0, 8'h00, '0};

    bus.cmd_v_i = 1'b0;
    bus.cmd_we_i = 1'b0;
    bus.cmd_addr_i = '0;
    bus.cmd_data_i = '0;
    bus.cmd_mask_i = '0;
    bus.rdata_yumi_i = 1'b0;
    bus.app_rdy_i = 1'b0;
    bus.app_wdf_rdy_i = 1'b0;
    bus.app_rd_data_valid_i = 1'b0;
    bus.app_rd_data_i = '0;
    bus.app_rd_data_end_i = 1'b0;

    // Reset state, with calib high so ready must still be masked.
    calib = 1'b1;
    bus.cmd_v_i = 1'b1;
    #12;
    chk("rst_ready", 512'(bus.cmd_ready_o), 512'(1'b0));
    chk("rst_en", 512'(bus.app_en_o), 512'(1'b0));
    chk("rst_rv", 512'(bus.rdata_v_o), 512'(1'b0));
    chk("rst_ovf", 512'(ovf), 512'(1'b0));
    calib = 1'b0;
    #1 rst_n = 1'b1;
    tick();

    foreach (vt[i]) begin
      {calib, bus.cmd_v_i, bus.cmd_we_i,
       bus.app_rdy_i, bus.app_wdf_rdy_i} = vt[i].in;
      bus.cmd_addr_i = vt[i].addr;
      bus.cmd_data_i = {MW{vt[i].db}};
      bus.cmd_mask_i = vt[i].mask;
      #1;
      chk($sformatf("v%0d_ready", i), 512'(bus.cmd_ready_o),
          512'(vt[i].ex[2]));
      chk($sformatf("v%0d_en", i), 512'(bus.app_en_o),
          512'(vt[i].ex[1]));
      chk($sformatf("v%0d_wren", i), 512'(bus.app_wdf_wren_o),
          512'(vt[i].ex[0]));
      chk($sformatf("v%0d_end", i), 512'(bus.app_wdf_end_o),
          512'(vt[i].ex[0]));
      chk($sformatf("v%0d_cmd", i), 512'(bus.app_cmd_o),
          512'(vt[i].ecmd));
      chk($sformatf("v%0d_addr", i), 512'(bus.app_addr_o),
          512'(vt[i].eaddr));
      chk($sformatf("v%0d_wdata", i), bus.app_wdf_data_o,
          vt[i].ex[0] ? {MW{vt[i].edb}} : '0);
      chk($sformatf("v%0d_wmask", i), 512'(bus.app_wdf_mask_o),
          512'(vt[i].emask));
      @(posedge clk);
      #1;
    end

    // Eight reads exhaust the credits.
    calib = 1'b1;
    bus.app_rdy_i = 1'b1;
    bus.app_wdf_rdy_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, AW'(28'h1000 + i*8));
      if (i == 0) chk("rd_cmd", 512'(bus.app_cmd_o), 512'(3'b001));
    end
    bus.cmd_v_i = 1'b1;
    tick();
    tick();
    #1;
    chk("no_credit_ready", 512'(bus.cmd_ready_o), 512'(1'b0));
    bus.cmd_v_i = 1'b0;
    for (int k = 0; k < 8; k++) mig_return(k);
    chk("full_ovf", 512'(ovf), 512'(1'b0));
    pop_n(1);
    #1;
    chk("credit_back_ready", 512'(bus.cmd_ready_o), 512'(1'b1));
    pop_n(7);
    #1;
    chk("drained_rv", 512'(bus.rdata_v_o), 512'(1'b0));

    // FIFO full: simultaneous push/pop, then a forced extra push.
    tick();
    for (int i = 0; i < 8; i++) issue(1'b0, AW'(28'h2000 + i*8));
    tick();
    for (int k = 10; k < 18; k++) mig_return(k);
    #1;
    chk("sim_pop_data", bus.rdata_o, sb.pop_front());
    bus.rdata_yumi_i = 1'b1;
    bus.app_rd_data_valid_i = 1'b1;
    bus.app_rd_data_i = dpat(18);
    sb.push_back(dpat(18));
    tick();
    bus.rdata_yumi_i = 1'b0;
    bus.app_rd_data_valid_i = 1'b0;
    #1;
    chk("sim_ovf", 512'(ovf), 512'(1'b0));
    issue(1'b0, AW'(28'h2100));
    bus.app_rd_data_valid_i = 1'b1;
    bus.app_rd_data_i = dpat(19);
    tick();
    bus.app_rd_data_valid_i = 1'b0;
    #1;
    chk("extra_push_ovf", 512'(ovf), 512'(1'b1));
    pop_n(8);
    #1;
    chk("post_ovf_rv", 512'(bus.rdata_v_o), 512'(1'b0));
    chk("ovf_sticky", 512'(ovf), 512'(1'b1));

    // Async reset in the middle of a stalled write.
    tick();
    issue(1'b0, AW'(28'h3000));
    mig_return(20);
    bus.app_rdy_i = 1'b0;
    bus.app_wdf_rdy_i = 1'b0;
    tick();
    issue(1'b1, AW'(28'h3100));
    #1;
    chk("pre_rst_en", 512'(bus.app_en_o), 512'(1'b1));
    chk("pre_rst_wren", 512'(bus.app_wdf_wren_o), 512'(1'b1));
    chk("pre_rst_rv", 512'(bus.rdata_v_o), 512'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("arst_en", 512'(bus.app_en_o), 512'(1'b0));
    chk("arst_wren", 512'(bus.app_wdf_wren_o), 512'(1'b0));
    chk("arst_rv", 512'(bus.rdata_v_o), 512'(1'b0));
    chk("arst_ovf", 512'(ovf), 512'(1'b0));
    sb.delete();
    #2 rst_n = 1'b1;
    bus.app_rdy_i = 1'b1;
    bus.app_wdf_rdy_i = 1'b1;
    tick();
    chk("post_rst_rv", 512'(bus.rdata_v_o), 512'(1'b0));
    for (int i = 0; i < 8; i++) issue(1'b0, AW'(28'h4000 + i*8));
    bus.cmd_v_i = 1'b1;
    tick();
    tick();
    #1;
    chk("post_rst_credits", 512'(bus.cmd_ready_o), 512'(1'b0));
    bus.cmd_v_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
